// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the 1-bit shift-register serial link.
// Word width and bit order must agree between transmitter and receiver.
package serial_link_pkg;

  localparam int SER_WORD_W = 8;

  typedef logic [SER_WORD_W-1:0] ser_word_t;

  // Bit 0 of a word is the first bit on the wire.
  localparam bit SER_LSB_FIRST = 1'b1;

endpackage : serial_link_pkg

// File: rtl/deser_shift_accum.sv
// Serial-to-parallel assembly: shift register, bit counter and word-done strobe.
// word_o/word_done_o are combinational so the parent can capture on the completing edge.
module deser_shift_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_i,
  input  logic             shift_i,
  input  logic             frame_clr_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_done_o,
  output logic [CNT_W-1:0] bit_cnt_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    word_done_o = 1'b0;
    // New bit enters at the MSB so the first bit ends up in bit 0.
    word_o      = {d_i, sr_q[WIDTH-1:1]};
    if (frame_clr_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      if (cnt_q == LAST_CNT) begin
        word_done_o = 1'b1;
        sr_d        = '0;
        cnt_d       = '0;
      end else begin
        sr_d  = word_o;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_cnt_o = cnt_q;

endmodule : deser_shift_accum

// File: rtl/serial_deserializer.sv
// Receive end of the serial link: assembles LSB-first words and offers them on
// a valid/ready port through a one-word holding register with sticky overrun.
module serial_deserializer
  import serial_link_pkg::*;
#(
  parameter int WIDTH = SER_WORD_W,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             shift,
  input  logic             frame_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [CNT_W-1:0] bit_cnt
);

  logic [WIDTH-1:0] word;
  logic             word_done;

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  deser_shift_accum #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_accum (
    .clk         (clk),
    .rst         (rst),
    .d_i         (d),
    .shift_i     (shift),
    .frame_clr_i (frame_clr),
    .word_o      (word),
    .word_done_o (word_done),
    .bit_cnt_o   (bit_cnt)
  );

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (overrun_clr) ovr_d = 1'b0;
    if (word_done) begin
      if (!valid_q || data_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        // Buffer full and consumer stalled: drop the new word, set wins over clear.
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

endmodule : serial_deserializer

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: directed scenarios plus a random
// run, all compared against a queue-based behavioural model of the link receiver.
module tb_serial_deserializer;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             d = 1'b0, shift = 1'b0, frame_clr = 1'b0;
  logic             data_ready = 1'b0, overrun_clr = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid, overrun;
  logic [CNT_W-1:0] bit_cnt;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  bit               m_bits[$];
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ovr;

  serial_deserializer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .d           (d),
    .shift       (shift),
    .frame_clr   (frame_clr),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .bit_cnt     (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_bits.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // One clock: drive at negedge, advance the model at posedge, return 1 after it.
  task automatic cycle(input logic di, input logic sh, input logic fc,
                       input logic rdy, input logic oc);
    logic             done;
    logic             set_ovr;
    logic [WIDTH-1:0] w;
    @(negedge clk);
    d = di; shift = sh; frame_clr = fc; data_ready = rdy; overrun_clr = oc;
    @(posedge clk);
    done = 1'b0; set_ovr = 1'b0; w = '0;
    if (fc) m_bits.delete();
    else if (sh) begin
      m_bits.push_back(di);
      if (m_bits.size() == WIDTH) begin
        for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
        done = 1'b1;
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin m_data = w; m_valid = 1'b1; end
      else set_ovr = 1'b1;
    end else if (m_valid && rdy) m_valid = 1'b0;
    if (set_ovr) m_ovr = 1'b1;
    else if (oc) m_ovr = 1'b0;
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy);
    for (int i = 0; i < WIDTH; i++) cycle(w[i], 1'b1, 1'b0, rdy, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; d = 1'b0; shift = 1'b0; frame_clr = 1'b0;
    data_ready = 1'b0; overrun_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    if ({data_out, data_valid, overrun, bit_cnt} !== '0) begin
      $display("FAIL reset: got data=%h valid=%b ovr=%b cnt=%0d, want all 0",
               data_out, data_valid, overrun, bit_cnt);
    end else n_pass++;
    n_total++;
  endtask

  task automatic test_single_word();
    logic [7:0] bits_v;
    apply_reset();
    bits_v = 8'b1010_0101;
    for (int i = 0; i < 7; i++) cycle(bits_v[i], 1'b1, 1'b0, 1'b0, 1'b0);
    if (data_valid !== 1'b0 || bit_cnt !== CNT_W'(7)) begin
      $display("FAIL single_pre: valid=%b cnt=%0d, want valid=0 cnt=7", data_valid, bit_cnt);
    end else n_pass++;
    n_total++;
    cycle(bits_v[7], 1'b1, 1'b0, 1'b0, 1'b0);
    if (data_out !== 8'hA5 || data_valid !== 1'b1 || bit_cnt !== '0) begin
      $display("FAIL single_word: data=%h valid=%b cnt=%0d, want A5/1/0",
               data_out, data_valid, bit_cnt);
    end else n_pass++;
    n_total++;
  endtask

  task automatic test_gapped_handshake();
    logic [7:0] w;
    apply_reset();
    w = 8'h3C;
    for (int i = 0; i < WIDTH; i++) begin
      cycle(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
      if (i != WIDTH - 1) cycle(w[i], 1'b0, 1'b0, 1'b1, 1'b0);
    end
    if (data_out !== 8'h3C || data_valid !== 1'b1) begin
      $display("FAIL gapped_word: data=%h valid=%b, want 3C/1", data_out, data_valid);
    end else n_pass++;
    n_total++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (data_out !== 8'h3C || data_valid !== 1'b1) begin
      $display("FAIL hold_stable: data=%h valid=%b, want 3C/1", data_out, data_valid);
    end else n_pass++;
    n_total++;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    if (data_valid !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL handshake_drop: valid=%b ovr=%b, want 0/0", data_valid, overrun);
    end else n_pass++;
    n_total++;
  endtask

  task automatic test_overrun();
    apply_reset();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    if (data_out !== 8'h11 || data_valid !== 1'b1 || overrun !== 1'b1 || bit_cnt !== '0) begin
      $display("FAIL overrun_set: data=%h valid=%b ovr=%b cnt=%0d, want 11/1/1/0",
               data_out, data_valid, overrun, bit_cnt);
    end else n_pass++;
    n_total++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (overrun !== 1'b0) begin
      $display("FAIL overrun_clr: ovr=%b, want 0", overrun);
    end else n_pass++;
    n_total++;
    send_word(8'h33, 1'b0);
    if (data_out !== 8'h11 || data_valid !== 1'b1 || overrun !== 1'b1) begin
      $display("FAIL overrun_again: data=%h valid=%b ovr=%b, want 11/1/1",
               data_out, data_valid, overrun);
    end else n_pass++;
    n_total++;
    // Clear and a fresh overrun on the same edge: set must win.
    for (int i = 0; i < WIDTH; i++)
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    if (overrun !== 1'b1) begin
      $display("FAIL overrun_set_wins: ovr=%b, want 1", overrun);
    end else n_pass++;
    n_total++;
    // Consume old word while the next one completes: new word replaces it, no overrun.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < WIDTH; i++)
      cycle(i[0], 1'b1, 1'b0, (i == WIDTH - 1), 1'b0);
    if (data_out !== 8'hAA || data_valid !== 1'b1 || overrun !== 1'b0) begin
      $display("FAIL complete_and_take: data=%h valid=%b ovr=%b, want AA/1/0",
               data_out, data_valid, overrun);
    end else n_pass++;
    n_total++;
  endtask

  task automatic test_back_to_back();
    int         vcnt;
    logic [7:0] words[2];
    apply_reset();
    vcnt = 0;
    words[0] = 8'hFF;
    words[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        cycle(words[k][i], 1'b1, 1'b0, 1'b1, 1'b0);
        if (data_valid) begin
          vcnt++;
          if (data_out !== words[k - 1 + (i == WIDTH - 1 ? 1 : 0)]) begin
            $display("FAIL b2b_data: data=%h, want %h", data_out,
                     words[k - 1 + (i == WIDTH - 1 ? 1 : 0)]);
          end else n_pass++;
          n_total++;
        end
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    if (data_valid) vcnt++;
    if (vcnt !== 2 || overrun !== 1'b0) begin
      $display("FAIL b2b_pulses: valid cycles=%0d ovr=%b, want 2/0", vcnt, overrun);
    end else n_pass++;
    n_total++;
  endtask

  task automatic test_frame_clr();
    apply_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    if (bit_cnt !== '0 || data_valid !== 1'b0) begin
      $display("FAIL frame_clr_cnt: cnt=%0d valid=%b, want 0/0", bit_cnt, data_valid);
    end else n_pass++;
    n_total++;
    send_word(8'h5A, 1'b0);
    if (data_out !== 8'h5A || data_valid !== 1'b1) begin
      $display("FAIL frame_clr_word: data=%h valid=%b, want 5A/1", data_out, data_valid);
    end else n_pass++;
    n_total++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    send_word(8'hC3, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    if ({data_out, data_valid, overrun, bit_cnt} !== '0) begin
      $display("FAIL async_reset: data=%h valid=%b ovr=%b cnt=%0d, want all 0",
               data_out, data_valid, overrun, bit_cnt);
    end else n_pass++;
    n_total++;
    rst = 1'b0;
    model_reset();
    send_word(8'h81, 1'b0);
    if (data_out !== 8'h81 || data_valid !== 1'b1) begin
      $display("FAIL post_reset_word: data=%h valid=%b, want 81/1", data_out, data_valid);
    end else n_pass++;
    n_total++;
  endtask

  task automatic test_random();
    int errs;
    apply_reset();
    errs = 0;
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom), ($urandom_range(9) < 7), ($urandom_range(19) == 0),
            1'($urandom), ($urandom_range(19) == 0));
      if ({data_out, data_valid, overrun, bit_cnt} !==
          {m_data, m_valid, m_ovr, CNT_W'(m_bits.size())}) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got data=%h valid=%b ovr=%b cnt=%0d, want %h/%b/%b/%0d",
                   n, data_out, data_valid, overrun, bit_cnt,
                   m_data, m_valid, m_ovr, m_bits.size());
        errs++;
      end else n_pass++;
      n_total++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_word();
    test_gapped_handshake();
    test_overrun();
    test_back_to_back();
    test_frame_clr();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_serial_deserializer

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Receive end of the team's 1-bit shift-register serial link.
- Accepts an LSB-first bit stream, qualified by a per-bit shift strobe, and assembles WIDTH-bit words.
- Each completed word is presented on a parallel valid/ready output with a one-word holding buffer.
- Sits between the serial link and any parallel consumer; detects overrun when the consumer stalls.

Parameters:
- WIDTH, 8, word length in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), width of the bit counter and bit_cnt port (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- d  input  1  serial data bit, sampled only when shift=1.
- shift  input  1  bit strobe; one bit accepted per cycle with shift=1.
- frame_clr  input  1  synchronous discard of the partially assembled word.
- data_out  output  WIDTH  completed word, bit 0 = first bit received.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out when data_valid=1 and data_ready=1.
- overrun  output  1  sticky: a completed word was dropped because the buffer was full.
- overrun_clr  input  1  synchronous clear of overrun.
- bit_cnt  output  CNT_W  number of bits in the partial word (0..WIDTH-1).

Behaviour:
- Reset values (asynchronous, immediate): data_out=0, data_valid=0, overrun=0, bit_cnt=0, assembly register=0.
- Assembly register:
  - Each shift=1 cycle shifts the register right by 1 and loads d into bit WIDTH-1.
  - After WIDTH strobes, the first bit received is in bit 0, matching the transmitter's LSB-first order.
  - shift=0 leaves the register and counter unchanged.
- Bit counter:
  - Increments on each accepted bit.
  - On the strobe that brings the count to WIDTH, the counter wraps to 0 in the same edge.
  - The register is cleared to 0 for the next word.
- Word completion, on the edge of the WIDTH-th strobe:
  - The full word, including the bit just received, is loaded into the holding register data_out.
  - data_valid=1 from the next cycle.
  - Latency: WIDTH-th strobe edge -> data_valid high 1 cycle later.
- Handshake:
  - A transfer occurs on any edge with data_valid=1 and data_ready=1.
  - data_valid drops on the following cycle unless a new word completes on the same edge.
  - data_out stays stable while data_valid=1 and no transfer occurs.
  - data_ready is ignored while data_valid=0.
- Simultaneous completion and transfer: the old word is consumed and the new word is loaded. data_valid stays 1 and no overrun occurs.
- Completion while data_valid=1 and data_ready=0:
  - The new word is dropped and data_out keeps the old word.
  - overrun is set to 1 on the next cycle.
  - The bit counter still wraps to 0, so the stream stays word-aligned.
- overrun:
  - Sticky until overrun_clr=1; the clear takes effect on the next edge.
  - If overrun_clr and a new overrun event occur on the same edge, set wins and overrun stays 1.
- frame_clr=1:
  - Clears the counter and assembly register on the next edge.
  - If shift=1 on the same cycle, frame_clr wins and the bit is discarded.
  - Does not affect data_out, data_valid or overrun.
- Reset asserted mid-word or mid-handshake:
  - All state clears immediately.
  - The partial word and any held word are lost.
  - The first strobe after reset release is bit 0 of a new word.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package serial_link_pkg, shared with the transmitter:
  - localparam SER_WORD_W = 8.
  - typedef logic [SER_WORD_W-1:0] ser_word_t.
  - LSB-first ordering constant.
- One sub-module is natural: deser_shift_accum, containing the assembly register, the bit counter, frame_clr handling, and the word_done pulse.
- The top level owns the holding register, the valid/ready logic and overrun.

Test Plan:
1. Single word: after reset, apply shift=1 for 8 consecutive cycles with d = 1,0,1,0,0,1,0,1 and data_ready=0 -> data_out=0xA5 and data_valid=1 one cycle after the 8th strobe; bit_cnt returns to 0.
2. Gapped strobes with handshake: send 0x3C with shift toggling 1/0 and d held during gaps, then data_ready=1 for one cycle -> data_out=0x3C and valid; after the transfer edge, data_valid=0.
3. Overrun: send 0x11 with data_ready=0, then send 0x22 -> data_out stays 0x11 and overrun=1. Apply overrun_clr=1 -> overrun=0 on the next cycle. Then send 0x33 -> it is correctly aligned and is also dropped (valid still 1, old word 0x11), so overrun=1 again.
4. Back-to-back with continuous data_ready=1: stream 0xFF then 0x00 with no gap -> two transfers, data_valid high for exactly 1 cycle each, no overrun.
5. frame_clr mid-word: send 3 bits, then frame_clr=1 together with shift=1 -> bit_cnt=0. Then send 0x5A -> data_out=0x5A with no leftover bits.
6. Async reset mid-word: after 5 bits, pulse rst between clock edges -> all outputs 0 immediately. Then send 0x81 -> data_out=0x81.
